// File: rtl/ledpi_pkg.sv
// Shared definitions for the LED panel command path: SPI word layout,
// opcodes and the command decoder FSM encoding.
package ledpi_pkg;

  localparam int SPI_WORD_W = 21;
  localparam int ADDR_W     = 10;
  localparam int COLOR_W    = 9;

  // Field positions inside one SPI word
  localparam int OP_MSB     = 20;
  localparam int OP_LSB     = 19;
  localparam int ADDR_LSB   = 9;
  localparam int COLOR_LSB  = 0;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_FILL  = 2'b01,
    OP_SWAP  = 2'b10,
    OP_NOP   = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_FILL  = 2'b10,
    ST_SWAP  = 2'b11
  } state_t;

  // Extract the opcode field of a received SPI word
  function automatic opcode_t word_opcode(input logic [SPI_WORD_W-1:0] word);
    return opcode_t'(word[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Frame-buffer write port plus buffer-swap request, shared between the
// command decoder (master) and the frame buffer / scan logic (slave).
interface spi_cmd_decoder_if #(
  parameter int ADDR_W  = 10,
  parameter int COLOR_W = 9
) ();

  logic               fb_wr_valid;
  logic               fb_wr_ready;
  logic [ADDR_W-1:0]  fb_wr_addr;
  logic [COLOR_W-1:0] fb_wr_color;
  logic               swap_pulse;

  modport master (
    output fb_wr_valid,
    output fb_wr_addr,
    output fb_wr_color,
    output swap_pulse,
    input  fb_wr_ready
  );

  modport slave (
    input  fb_wr_valid,
    input  fb_wr_addr,
    input  fb_wr_color,
    input  swap_pulse,
    output fb_wr_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head. A push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign data_o    = mem_q[rd_ptr_q];

  // Storage array: written on accepted pushes, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns completed SPI words into frame-buffer writes and buffer-swap pulses.
// The rising edge of chip select (end of packet) queues the word; the FSM
// executes queued commands strictly in order.
module spi_cmd_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ledpi_pkg::ADDR_W,
  parameter int COLOR_W    = ledpi_pkg::COLOR_W,
  parameter int NUM_PIXELS = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cs,
  input  logic [ledpi_pkg::SPI_WORD_W-1:0] received_data,
  spi_cmd_decoder_if.master                fb,
  output logic                             busy,
  output logic                             overflow
);

  import ledpi_pkg::*;

  logic                  cs_meta_q;
  logic                  cs_sync_q;
  logic                  cs_prev_q;
  logic                  cs_rise_s;

  logic [SPI_WORD_W-1:0] head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  pop_s;

  state_t                state_q;
  logic                  valid_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [COLOR_W-1:0]    color_q;
  logic                  swap_q;
  logic                  busy_q;
  logic                  overflow_q;
  logic                  overflow_d;

  // Synchronize chip select and remember the previous value; all three flops
  // reset high so leaving reset never looks like an end of packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
      cs_prev_q <= 1'b1;
    end else begin
      cs_meta_q <= cs;
      cs_sync_q <= cs_meta_q;
      cs_prev_q <= cs_sync_q;
    end
  end

  assign cs_rise_s = cs_sync_q & ~cs_prev_q;
  assign pop_s     = (state_q == ST_IDLE) & ~fifo_empty_s;

  sync_fifo #(
    .WIDTH (SPI_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cs_rise_s),
    .pop_i   (pop_s),
    .data_i  (received_data),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // A word is lost only when the FIFO is full and no pop frees a slot
  always_comb begin
    overflow_d = overflow_q;
    if (cs_rise_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // Command FSM with registered write port, swap pulse and busy; addr_q also
  // serves as the FILL address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      color_q <= {COLOR_W{1'b0}};
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_q != ST_IDLE) | ~fifo_empty_s;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            case (word_opcode(head_s))
              OP_WRITE: begin
                valid_q <= 1'b1;
                addr_q  <= head_s[ADDR_LSB +: ADDR_W];
                color_q <= head_s[COLOR_LSB +: COLOR_W];
                state_q <= ST_WRITE;
              end
              OP_FILL: begin
                valid_q <= 1'b1;
                addr_q  <= {ADDR_W{1'b0}};
                color_q <= head_s[COLOR_LSB +: COLOR_W];
                state_q <= ST_FILL;
              end
              OP_SWAP: begin
                swap_q  <= 1'b1;
                state_q <= ST_SWAP;
              end
              default: begin
                state_q <= ST_IDLE;
              end
            endcase
          end
        end
        ST_WRITE: begin
          if (fb.fb_wr_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (fb.fb_wr_ready) begin
            if (addr_q == ADDR_W'(NUM_PIXELS - 1)) begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        ST_SWAP: begin
          swap_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          swap_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fb.fb_wr_valid = valid_q;
  assign fb.fb_wr_addr  = addr_q;
  assign fb.fb_wr_color = color_q;
  assign fb.swap_pulse  = swap_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: every queued command pushes its
// expected writes/swap; a negedge monitor pops and compares DUT output.
module tb_spi_cmd_decoder;

  typedef struct packed {
    logic       is_swap;
    logic [9:0] addr;
    logic [8:0] color;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cs;
  logic [20:0] received_data;
  logic        busy;
  logic        overflow;
  logic        ready_man;
  logic        rand_ready;
  logic        rnd_bit;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  spi_cmd_decoder_if #(.ADDR_W(10), .COLOR_W(9)) fb ();

  spi_cmd_decoder #(
    .FIFO_DEPTH (4),
    .ADDR_W     (10),
    .COLOR_W    (9),
    .NUM_PIXELS (1024)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cs            (cs),
    .received_data (received_data),
    .fb            (fb),
    .busy          (busy),
    .overflow      (overflow)
  );

  assign fb.fb_wr_ready = rand_ready ? rnd_bit : ready_man;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: handshakes, swap pulses and hold-while-stalled behaviour
  logic       prev_pend;
  logic       prev_swap;
  logic [9:0] prev_addr;
  logic [8:0] prev_color;
  initial begin
    exp_t e;
    prev_pend = 1'b0;
    prev_swap = 1'b0;
    prev_addr = 10'd0;
    prev_color = 9'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pend = 1'b0;
        prev_swap = 1'b0;
      end else begin
        if (prev_pend) begin
          check_val("hold_valid", 32'(fb.fb_wr_valid), 32'd1);
          check_val("hold_addr", 32'(fb.fb_wr_addr), 32'(prev_addr));
          check_val("hold_color", 32'(fb.fb_wr_color), 32'(prev_color));
        end
        if (fb.fb_wr_valid && fb.fb_wr_ready) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_write", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_val("wr_kind", 32'(1'b0), 32'(e.is_swap));
            check_val("wr_addr", 32'(fb.fb_wr_addr), 32'(e.addr));
            check_val("wr_color", 32'(fb.fb_wr_color), 32'(e.color));
          end
        end
        if (fb.swap_pulse) begin
          check_val("swap_width", 32'(prev_swap), 32'd0);
          if (exp_q.size() == 0) begin
            check_val("unexpected_swap", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_val("swap_kind", 32'(1'b1), 32'(e.is_swap));
          end
        end
        prev_pend  = fb.fb_wr_valid & ~fb.fb_wr_ready;
        prev_addr  = fb.fb_wr_addr;
        prev_color = fb.fb_wr_color;
        prev_swap  = fb.swap_pulse;
      end
    end
  end

  // Record what a word should produce (when it is expected to be accepted)
  task automatic expect_word(input logic [20:0] w);
    exp_t e;
    logic [1:0] op;
    op = w[20:19];
    case (op)
      2'b00: begin
        e.is_swap = 1'b0; e.addr = w[18:9]; e.color = w[8:0];
        exp_q.push_back(e);
      end
      2'b01: begin
        for (int a = 0; a < 1024; a++) begin
          e.is_swap = 1'b0; e.addr = 10'(a); e.color = w[8:0];
          exp_q.push_back(e);
        end
      end
      2'b10: begin
        e.is_swap = 1'b1; e.addr = 10'd0; e.color = 9'd0;
        exp_q.push_back(e);
      end
      default: begin
      end
    endcase
  endtask

  // One SPI packet: cs low for two cycles, rise, then idle high for four
  task automatic cs_pulse(input logic [20:0] w, input logic accepted);
    if (accepted) expect_word(w);
    received_data = w;
    cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cs = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!fb.fb_wr_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("wait_valid", 32'(fb.fb_wr_valid), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cs = 1'b1;
    received_data = 21'd0;
    ready_man = 1'b0;
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(fb.fb_wr_valid), 32'd0);
    check_val("rst_addr", 32'(fb.fb_wr_addr), 32'd0);
    check_val("rst_color", 32'(fb.fb_wr_color), 32'd0);
    check_val("rst_swap", 32'(fb.swap_pulse), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_after_rst", 32'(fb.fb_wr_valid), 32'd0);

    // Single WRITE with ready high, latency measured from cs rise
    ready_man = 1'b1;
    expect_word(21'h00BFF);
    received_data = 21'h00BFF;
    cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cs = 1'b1;
    n = 0;
    while (!(fb.fb_wr_valid && fb.fb_wr_ready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("t1_latency_ok", 32'(n >= 2 && n <= 5), 32'd1);
    drain(50);

    // WRITE stalled for 10 cycles
    ready_man = 1'b0;
    cs_pulse(21'h00BFF, 1'b1);
    wait_valid(20);
    repeat (10) @(posedge clk);
    #1;
    check_val("t2_stall_valid", 32'(fb.fb_wr_valid), 32'd1);
    check_val("t2_stall_addr", 32'(fb.fb_wr_addr), 32'd5);
    check_val("t2_stall_color", 32'(fb.fb_wr_color), 32'h1FF);
    ready_man = 1'b1;
    drain(50);
    check_val("t2_valid_drop", 32'(fb.fb_wr_valid), 32'd0);

    // FILL with ready high: 1024 consecutive valid cycles
    cs_pulse(21'h80007, 1'b1);
    wait_valid(20);
    n = 0;
    while (fb.fb_wr_valid && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("t3_fill_cycles", 32'(n), 32'd1024);
    drain(50);
    repeat (3) @(posedge clk);
    #1;
    check_val("t3_busy", 32'(busy), 32'd0);

    // FILL then SWAP under random backpressure
    rand_ready = 1'b1;
    cs_pulse(21'h80007, 1'b1);
    cs_pulse(21'h100000, 1'b1);
    drain(6000);
    rand_ready = 1'b0;
    ready_man = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("t4_busy", 32'(busy), 32'd0);

    // Overflow: six WRITEs with ready low, the sixth is dropped
    check_val("t5_overflow_pre", 32'(overflow), 32'd0);
    ready_man = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cs_pulse({2'b00, 10'(i), 9'(i + 16)}, i <= 5);
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("t5_overflow", 32'(overflow), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd1);
    ready_man = 1'b1;
    drain(100);

    // Reset in the middle of a FILL with a SWAP queued behind it
    cs_pulse(21'h80003, 1'b1);
    cs_pulse(21'h100000, 1'b1);
    n = 0;
    while (!(fb.fb_wr_valid && fb.fb_wr_addr == 10'd300) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("t6_reach_300", 32'(fb.fb_wr_addr), 32'd300);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_val("t6_rst_valid", 32'(fb.fb_wr_valid), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_swap", 32'(fb.swap_pulse), 32'd0);
    check_val("t6_rst_overflow", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_val("t6_quiet_valid", 32'(fb.fb_wr_valid), 32'd0);
    check_val("t6_quiet_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
